pipe_ctrl: RTL and testbench
============================

# pipe_ctrl

Central stall/flush sequencer for the five-stage pipeline (PC, IF_ID, ID_EX, EX_MEM, MEM_WB). It arbitrates hazard requests from ID (load-use), EX (multi-cycle op, branch redirect) and MEM (data-memory wait). It drives one hold bit and one bubble bit per pipeline register, so that stalls and flushes happen consistently across stages. It also sequences a drain-and-halt for debug and flags stalls that never resolve.

## Interface
- DRAIN_CYCLES, 4, number of cycles the pipe must advance with the PC held before it is empty
- TIMEOUT, 255, count of consecutive stall-request cycles that sets timeout_o (8-bit counter)
- CNT_W, 32, width of the performance counters

- clk  input  1  clock (rising edge)
- rst  input  1  asynchronous, active-low reset
- id_stall_req  input  1  load-use hazard detected in ID
- ex_stall_req  input  1  multi-cycle EX operation not finished
- mem_stall_req  input  1  data memory not ready
- flush_req  input  1  branch/jump redirect resolved in EX (1-cycle pulse)
- halt_req  input  1  debug halt request (level)
- stall_o  output  5  hold bit per register, bit0 PC … bit4 MEM_WB
- bubble_o  output  5  load-NOP bit per register; same bit order
- halted_o  output  1  pipeline empty and PC frozen
- timeout_o  output  1  sticky stall-timeout error
- perf_stall_cnt_o  output  CNT_W  cycles with stall_o[0]=1 (excluding the HALTED state)
- perf_flush_cnt_o  output  CNT_W  flushes applied

## Operation
- FSM states: RUN, FLUSH_PEND, DRAIN, HALTED. The FSM resets to RUN.
- Stall priority is mem > ex > id. The highest requesting stage k holds stall_o[k:0] and sets bubble_o[k+1].
  - mem_stall_req: stall=01111, bubble=10000.
  - ex_stall_req: stall=00111, bubble=01000.
  - id_stall_req: stall=00011, bubble=00100.
- Flush handling:
  - flush_req with no ex/mem request: stall=00000, bubble=00110.
  - Flush overrides id_stall_req, because the stalled instruction is squashed.
  - flush_req during an ex/mem stall moves the FSM to FLUSH_PEND. The flush is applied in the first cycle in which both ex/mem requests are low, then the FSM returns to RUN.
  - A further flush_req while in FLUSH_PEND is merged into the pending one (counted once).
- Halt sequence:
  - halt_req is accepted only in RUN, with no stall request and no flush this cycle. The FSM moves to DRAIN and the drain counter loads DRAIN_CYCLES.
  - In DRAIN: stall_o[0]=1 and bubble_o[1]=1, OR'd with any stall pattern. The counter decrements only in cycles without an ex/mem request. At 0 the FSM moves to HALTED.
  - flush_req during DRAIN applies bubble=00110 with stall_o[0]=0 that cycle, so the PC takes the target, and reloads the counter.
  - halt_req low in DRAIN or HALTED returns the FSM to RUN next cycle.
  - HALTED: stall=00001, bubble=00010, halted_o=1.
- Timeout:
  - An 8-bit saturating counter increments on each cycle with any stall request and clears on a cycle with none.
  - Reaching TIMEOUT sets timeout_o. It stays set until reset.

## Timing
- stall_o and bubble_o are combinational from the request inputs and the registered state, so they are valid in the same cycle as the request.
- State, counters, halted_o and timeout_o are registered and update on the clk edge.
- Latencies:
  - halt_req rising (idle pipe) → DRAIN next edge → halted_o after DRAIN_CYCLES more edges.
  - halt_req falling → RUN, halted_o=0 one edge later.
- With rst low, every output is 0 immediately and asynchronously. This includes the counters.
- Reset mid-drain or mid-FLUSH_PEND discards the pending operation.

## Configuration
- PIPE_CTRL_PERF_EN defined: both CNT_W counters are implemented.
  - The counters wrap modulo 2^CNT_W.
  - perf_flush_cnt_o increments in the cycle a flush is applied, not when it is pended.
- PIPE_CTRL_PERF_EN undefined: no counter flops are implemented, and perf_stall_cnt_o and perf_flush_cnt_o are tied to 0.

## Test plan
- Single-stage stalls:
  - id_stall_req for 1 cycle → stall=00011, bubble=00100; next cycle 00000/00000.
  - mem_stall_req for 3 cycles → stall=01111, bubble=10000 each cycle.
- Simultaneous requests: id+ex+mem all high → mem pattern wins (01111/10000). flush_req together with id_stall_req only → 00000/00110.
- Pended flush: flush_req pulsed during a 2-cycle mem stall → FLUSH_PEND; bubble=00110 appears in the cycle mem_stall_req drops; perf_flush_cnt_o +1 (PERF_EN).
- Halt:
  - halt_req held on an idle pipe → halted_o=1 at edge 1+DRAIN_CYCLES (5).
  - ex_stall_req for 2 cycles during DRAIN → halted_o delayed by 2 cycles.
  - halt_req released → halted_o=0 next edge.
- Timeout and async reset:
  - mem_stall_req held 255 cycles → timeout_o=1 at edge 255 and stays set after the request drops.
  - rst low mid-DRAIN → all outputs 0 with no clock edge; state RUN after release.

Source files
------------

// File: rtl/pipe_ctrl.sv
// Stall/flush sequencer for the five-stage pipeline: hazard arbitration, drain-and-halt, timeout.
// Optional performance counters are built when PIPE_CTRL_PERF_EN is defined.
module pipe_ctrl #(
   parameter int unsigned DRAIN_CYCLES = 4,
   parameter int unsigned TIMEOUT      = 255,
   parameter int unsigned CNT_W        = 32
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             id_stall_req,
   input  logic             ex_stall_req,
   input  logic             mem_stall_req,
   input  logic             flush_req,
   input  logic             halt_req,
   output logic [4:0]       stall_o,
   output logic [4:0]       bubble_o,
   output logic             halted_o,
   output logic             timeout_o,
   output logic [CNT_W-1:0] perf_stall_cnt_o,
   output logic [CNT_W-1:0] perf_flush_cnt_o
);

   typedef enum logic [1:0] {StRun, StFlushPend, StDrain, StHalted} state_e;

   localparam logic [4:0] FlushBubble = 5'b00110;

   state_e     state_q, state_d;
   logic [7:0] drain_q, drain_d;
   logic [7:0] to_cnt_q, to_cnt_d;
   logic       timeout_q, timeout_d;
   logic [4:0] stall_pat, bubble_pat;
   logic [4:0] stall_raw, bubble_raw;
   logic       ex_mem_req, any_req, flush_applied;

   assign ex_mem_req = ex_stall_req | mem_stall_req;
   assign any_req    = ex_mem_req | id_stall_req;

   always_comb begin
      stall_pat  = 5'b00000;
      bubble_pat = 5'b00000;
      if (mem_stall_req) begin
         stall_pat  = 5'b01111;
         bubble_pat = 5'b10000;
      end else if (ex_stall_req) begin
         stall_pat  = 5'b00111;
         bubble_pat = 5'b01000;
      end else if (id_stall_req) begin
         stall_pat  = 5'b00011;
         bubble_pat = 5'b00100;
      end
   end

   always_comb begin
      state_d       = state_q;
      drain_d       = drain_q;
      stall_raw     = stall_pat;
      bubble_raw    = bubble_pat;
      flush_applied = 1'b0;
      unique case (state_q)
         StRun: begin
            if (ex_mem_req) begin
               if (flush_req) state_d = StFlushPend;
            end else if (flush_req) begin
               // The flush squashes any load-use stall in ID.
               stall_raw     = 5'b00000;
               bubble_raw    = FlushBubble;
               flush_applied = 1'b1;
            end else if (!id_stall_req && halt_req) begin
               state_d = StDrain;
               drain_d = 8'(DRAIN_CYCLES);
            end
         end
         StFlushPend: begin
            if (!ex_mem_req) begin
               stall_raw     = 5'b00000;
               bubble_raw    = FlushBubble;
               flush_applied = 1'b1;
               state_d       = StRun;
            end
         end
         StDrain: begin
            if (flush_req && !ex_mem_req) begin
               // PC must take the redirect target, so release it for this cycle.
               stall_raw     = 5'b00000;
               bubble_raw    = FlushBubble;
               flush_applied = 1'b1;
               drain_d       = 8'(DRAIN_CYCLES);
            end else begin
               stall_raw  = stall_pat | 5'b00001;
               bubble_raw = bubble_pat | 5'b00010;
               if (flush_req) begin
                  state_d = StFlushPend;
               end else if (!ex_mem_req) begin
                  if (drain_q <= 8'd1) state_d = StHalted;
                  else drain_d = drain_q - 8'd1;
               end
            end
            if (!halt_req && state_d != StFlushPend) state_d = StRun;
         end
         StHalted: begin
            stall_raw  = 5'b00001;
            bubble_raw = 5'b00010;
            if (!halt_req) state_d = StRun;
         end
         default: state_d = StRun;
      endcase
   end

   always_comb begin
      if (!any_req) to_cnt_d = 8'd0;
      else if (to_cnt_q == 8'hff) to_cnt_d = to_cnt_q;
      else to_cnt_d = to_cnt_q + 8'd1;
      timeout_d = timeout_q | (any_req && ({24'd0, to_cnt_d} >= TIMEOUT));
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q   <= StRun;
         drain_q   <= 8'd0;
         to_cnt_q  <= 8'd0;
         timeout_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         drain_q   <= drain_d;
         to_cnt_q  <= to_cnt_d;
         timeout_q <= timeout_d;
      end
   end

   // Combinational outputs are forced low while reset is held.
   assign stall_o   = rst ? stall_raw : 5'b00000;
   assign bubble_o  = rst ? bubble_raw : 5'b00000;
   assign halted_o  = (state_q == StHalted);
   assign timeout_o = timeout_q;

`ifdef PIPE_CTRL_PERF_EN
   logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
   logic [CNT_W-1:0] flush_cnt_q, flush_cnt_d;
   logic             stall_inc;

   assign stall_inc = stall_raw[0] && (state_q != StHalted);

   always_comb begin
      stall_cnt_d = stall_cnt_q + {{(CNT_W-1){1'b0}}, stall_inc};
      flush_cnt_d = flush_cnt_q + {{(CNT_W-1){1'b0}}, flush_applied};
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         stall_cnt_q <= '0;
         flush_cnt_q <= '0;
      end else begin
         stall_cnt_q <= stall_cnt_d;
         flush_cnt_q <= flush_cnt_d;
      end
   end

   assign perf_stall_cnt_o = stall_cnt_q;
   assign perf_flush_cnt_o = flush_cnt_q;
`else
   logic unused_perf;
   assign unused_perf      = flush_applied;
   assign perf_stall_cnt_o = '0;
   assign perf_flush_cnt_o = '0;
`endif

endmodule

// File: tb/tb_pipe_ctrl.sv
// Scoreboard bench for pipe_ctrl: directed per-cycle vectors queue expectations, a negedge
// monitor pops and compares them against the DUT outputs.
module tb_pipe_ctrl;

   logic        clk = 1'b0;
   logic        rst;
   logic        id_stall_req, ex_stall_req, mem_stall_req, flush_req, halt_req;
   logic [4:0]  stall_o, bubble_o;
   logic        halted_o, timeout_o;
   logic [31:0] perf_stall_cnt_o, perf_flush_cnt_o;

   typedef struct packed {
      logic [4:0]  stall;
      logic [4:0]  bubble;
      logic        halted;
      logic        timeout;
      logic [31:0] pstall;
      logic [31:0] pflush;
   } exp_t;

   exp_t        sb[$];
   int          checks = 0;
   int          errors = 0;
   int          cyc = 0;
   logic [31:0] exp_stall_cnt = 0;
   logic [31:0] exp_flush_cnt = 0;

   pipe_ctrl #(
      .DRAIN_CYCLES(4),
      .TIMEOUT     (255),
      .CNT_W       (32)
   ) dut (
      .clk             (clk),
      .rst             (rst),
      .id_stall_req    (id_stall_req),
      .ex_stall_req    (ex_stall_req),
      .mem_stall_req   (mem_stall_req),
      .flush_req       (flush_req),
      .halt_req        (halt_req),
      .stall_o         (stall_o),
      .bubble_o        (bubble_o),
      .halted_o        (halted_o),
      .timeout_o       (timeout_o),
      .perf_stall_cnt_o(perf_stall_cnt_o),
      .perf_flush_cnt_o(perf_flush_cnt_o)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input int c, input logic [31:0] act,
                      input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s cycle %0d: got %0h want %0h", name, c, act, exp);
      end
   endtask

   // Drive one cycle's requests just after the edge and queue what the DUT must show.
   task automatic step(input logic id, input logic ex, input logic mem, input logic fl,
                       input logic hlt, input logic [4:0] s, input logic [4:0] b,
                       input logic h, input logic t, input logic applied);
      exp_t e;
      @(posedge clk);
      #1;
      id_stall_req  = id;
      ex_stall_req  = ex;
      mem_stall_req = mem;
      flush_req     = fl;
      halt_req      = hlt;
      e.stall   = s;
      e.bubble  = b;
      e.halted  = h;
      e.timeout = t;
`ifdef PIPE_CTRL_PERF_EN
      e.pstall  = exp_stall_cnt;
      e.pflush  = exp_flush_cnt;
`else
      e.pstall  = 32'd0;
      e.pflush  = 32'd0;
`endif
      sb.push_back(e);
      if (s[0] && !h) exp_stall_cnt = exp_stall_cnt + 1;
      if (applied) exp_flush_cnt = exp_flush_cnt + 1;
   endtask

   task automatic chk_all_zero(input string tag);
      chk({tag, "_stall"}, cyc, {27'd0, stall_o}, 32'd0);
      chk({tag, "_bubble"}, cyc, {27'd0, bubble_o}, 32'd0);
      chk({tag, "_halted"}, cyc, {31'd0, halted_o}, 32'd0);
      chk({tag, "_timeout"}, cyc, {31'd0, timeout_o}, 32'd0);
      chk({tag, "_pstall"}, cyc, perf_stall_cnt_o, 32'd0);
      chk({tag, "_pflush"}, cyc, perf_flush_cnt_o, 32'd0);
   endtask

   always @(negedge clk) begin
      exp_t e;
      cyc++;
      if (sb.size() > 0) begin
         e = sb.pop_front();
         chk("stall_o", cyc, {27'd0, stall_o}, {27'd0, e.stall});
         chk("bubble_o", cyc, {27'd0, bubble_o}, {27'd0, e.bubble});
         chk("halted_o", cyc, {31'd0, halted_o}, {31'd0, e.halted});
         chk("timeout_o", cyc, {31'd0, timeout_o}, {31'd0, e.timeout});
         chk("perf_stall", cyc, perf_stall_cnt_o, e.pstall);
         chk("perf_flush", cyc, perf_flush_cnt_o, e.pflush);
      end
   end

   initial begin
      #100000;
      $display("FAIL watchdog expired: got running want finished");
      $fatal(1, "watchdog");
   end

   initial begin
      rst           = 1'b0;
      id_stall_req  = 1'b0;
      ex_stall_req  = 1'b0;
      mem_stall_req = 1'b1;
      flush_req     = 1'b0;
      halt_req      = 1'b0;
      #2;
      chk_all_zero("reset");
      mem_stall_req = 1'b0;
      @(negedge clk);
      rst = 1'b1;

      // id ex mem fl halt | stall bubble halted timeout applied
      step(0, 0, 0, 0, 0, 5'b00000, 5'b00000, 0, 0, 0);
      step(1, 0, 0, 0, 0, 5'b00011, 5'b00100, 0, 0, 0);
      step(0, 0, 0, 0, 0, 5'b00000, 5'b00000, 0, 0, 0);
      repeat (3) step(0, 0, 1, 0, 0, 5'b01111, 5'b10000, 0, 0, 0);
      step(0, 0, 0, 0, 0, 5'b00000, 5'b00000, 0, 0, 0);
      step(1, 1, 1, 0, 0, 5'b01111, 5'b10000, 0, 0, 0);
      step(0, 0, 0, 0, 0, 5'b00000, 5'b00000, 0, 0, 0);
      step(1, 0, 0, 1, 0, 5'b00000, 5'b00110, 0, 0, 1);
      step(0, 1, 0, 0, 0, 5'b00111, 5'b01000, 0, 0, 0);
      step(0, 0, 0, 0, 0, 5'b00000, 5'b00000, 0, 0, 0);

      // Flush pended behind a two-cycle mem stall.
      step(0, 0, 1, 1, 0, 5'b01111, 5'b10000, 0, 0, 0);
      step(0, 0, 1, 0, 0, 5'b01111, 5'b10000, 0, 0, 0);
      step(0, 0, 0, 0, 0, 5'b00000, 5'b00110, 0, 0, 1);
      step(0, 0, 0, 0, 0, 5'b00000, 5'b00000, 0, 0, 0);

      // Halt on an idle pipe: DRAIN after 1 edge, HALTED after 4 more.
      step(0, 0, 0, 0, 1, 5'b00000, 5'b00000, 0, 0, 0);
      repeat (4) step(0, 0, 0, 0, 1, 5'b00001, 5'b00010, 0, 0, 0);
      step(0, 0, 0, 0, 1, 5'b00001, 5'b00010, 1, 0, 0);
      step(0, 0, 0, 0, 0, 5'b00001, 5'b00010, 1, 0, 0);
      step(0, 0, 0, 0, 0, 5'b00000, 5'b00000, 0, 0, 0);

      // ex stall for 2 cycles inside DRAIN delays halted_o by 2.
      step(0, 0, 0, 0, 1, 5'b00000, 5'b00000, 0, 0, 0);
      step(0, 0, 0, 0, 1, 5'b00001, 5'b00010, 0, 0, 0);
      repeat (2) step(0, 1, 0, 0, 1, 5'b00111, 5'b01010, 0, 0, 0);
      repeat (3) step(0, 0, 0, 0, 1, 5'b00001, 5'b00010, 0, 0, 0);
      step(0, 0, 0, 0, 1, 5'b00001, 5'b00010, 1, 0, 0);
      step(0, 0, 0, 0, 0, 5'b00001, 5'b00010, 1, 0, 0);
      step(0, 0, 0, 0, 0, 5'b00000, 5'b00000, 0, 0, 0);

      // Flush inside DRAIN frees the PC for one cycle and reloads the drain count.
      step(0, 0, 0, 0, 1, 5'b00000, 5'b00000, 0, 0, 0);
      step(0, 0, 0, 0, 1, 5'b00001, 5'b00010, 0, 0, 0);
      step(0, 0, 0, 1, 1, 5'b00000, 5'b00110, 0, 0, 1);
      repeat (4) step(0, 0, 0, 0, 1, 5'b00001, 5'b00010, 0, 0, 0);
      step(0, 0, 0, 0, 1, 5'b00001, 5'b00010, 1, 0, 0);
      step(0, 0, 0, 0, 0, 5'b00001, 5'b00010, 1, 0, 0);
      step(0, 0, 0, 0, 0, 5'b00000, 5'b00000, 0, 0, 0);

      // 255 consecutive stall cycles set the sticky timeout.
      for (int i = 0; i < 255; i++) step(0, 0, 1, 0, 0, 5'b01111, 5'b10000, 0, 0, 0);
      repeat (2) step(0, 0, 0, 0, 0, 5'b00000, 5'b00000, 0, 1, 0);

      // Asynchronous reset in the middle of a drain.
      step(0, 0, 0, 0, 1, 5'b00000, 5'b00000, 0, 1, 0);
      step(0, 0, 0, 0, 1, 5'b00001, 5'b00010, 0, 1, 0);
      @(posedge clk);
      #1;
      mem_stall_req = 1'b1;
      #2;
      rst = 1'b0;
      exp_stall_cnt = 0;
      exp_flush_cnt = 0;
      #1;
      chk_all_zero("midreset");
      mem_stall_req = 1'b0;
      halt_req      = 1'b0;
      id_stall_req  = 1'b1;
      @(posedge clk);
      #3;
      rst = 1'b1;
      step(1, 0, 0, 0, 0, 5'b00011, 5'b00100, 0, 0, 0);
      step(0, 0, 0, 0, 0, 5'b00000, 5'b00000, 0, 0, 0);

      repeat (2) @(posedge clk);
      chk("sb_drained", cyc, sb.size(), 32'd0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
